// File: rtl/mux_rr_scheduler_if.sv
// Handshake bundle between the requesters and the round-robin mux scheduler.
// The master side drives requests and enable; the slave side returns grants.
interface mux_rr_scheduler_if #(
    parameter int N_REQ = 16,
    parameter int SEL_W = 4
);
    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             last;

    modport master (
        output en, req,
        input  gnt, sel, busy, last
    );

    modport slave (
        input  en, req,
        output gnt, sel, busy, last
    );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin burst scheduler sharing one serial mux between N_REQ requesters.
// Drives a one-hot grant, the mux select and a busy flag that gates the mux reset.
module mux_rr_scheduler #(
    parameter int N_REQ     = 16,
    parameter int SEL_W     = 4,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rstn,
    mux_rr_scheduler_if.slave bus
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             can_grant;
    logic             release_now;
    logic             load;
    logic             drop;
    logic [SEL_W-1:0] winner;

    // First set request at or after p, wrapping modulo N_REQ (N_REQ == 2**SEL_W).
    function automatic logic [SEL_W-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                     input logic [SEL_W-1:0] p);
        logic [SEL_W-1:0] w;
        logic [SEL_W-1:0] idx;
        logic             found;
        w     = p;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = p + SEL_W'(i);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        can_grant   = bus.en && (|bus.req);
        winner      = pick_winner(bus.req, ptr_q);
        release_now = (state_q == GRANT) && ((cnt_q == CNT_LAST) || !bus.req[sel_q]);
        load        = 1'b0;
        drop        = 1'b0;

        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;

        if (state_q == IDLE) begin
            load = can_grant;
        end else if (release_now) begin
            // Zero-bubble handover: a pending request is granted on the release edge.
            load = can_grant;
            drop = !can_grant;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (load) begin
            state_d = GRANT;
            gnt_d   = N_REQ'(1) << winner;
            sel_d   = winner;
            busy_d  = 1'b1;
            cnt_d   = '0;
            ptr_d   = winner + SEL_W'(1);
        end else if (drop) begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end

        last_d = busy_d && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.last = last_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the scheduler.
module tb_mux_rr_scheduler;

    localparam int N  = 16;
    localparam int SW = 4;
    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [N-1:0] mux_in = '0;
    logic        mux_out;
    logic [N+SW+1:0] obs;
    int          checks = 0;
    int          errors = 0;

    int m_owner;
    int m_cnt;
    int m_ptr;

    mux_rr_scheduler_if #(.N_REQ(N), .SEL_W(SW)) bus();

    mux_rr_scheduler #(.N_REQ(N), .SEL_W(SW), .BURST_LEN(BL)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign obs     = {bus.gnt, bus.sel, bus.busy, bus.last};
    assign mux_out = bus.busy ? mux_in[bus.sel] : 1'b0;

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    function automatic int model_pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic model_update(input logic e, input logic [N-1:0] r);
        int  w;
        bit  rel;
        w = model_pick(r);
        if (m_owner < 0) begin
            rel = 1'b1;
        end else begin
            rel = (m_cnt == BL - 1) || (r[m_owner] == 1'b0);
        end
        if (!rel) begin
            m_cnt = m_cnt + 1;
        end else if (e && r != 0) begin
            m_owner = w;
            m_cnt   = 0;
            m_ptr   = (w + 1) % N;
        end else begin
            m_owner = -1;
            m_cnt   = 0;
        end
    endtask

    function automatic logic [N+SW+1:0] exp_vec();
        logic [N-1:0]  g;
        logic [SW-1:0] s;
        logic          b;
        logic          l;
        b = (m_owner >= 0);
        g = b ? (N'(1) << m_owner) : '0;
        s = b ? SW'(m_owner) : '0;
        l = b && (m_cnt == BL - 1);
        return {g, s, b, l};
    endfunction

    function automatic logic exp_mux();
        return (m_owner >= 0) ? mux_in[m_owner] : 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update(bus.en, bus.req);
        #1;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        bus.req = '0;
        bus.en  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.req = '0;
        bus.en  = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, {(N+SW+2){1'b0}});
        end
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'hFFFF;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL pre_reset_burst[%0d]: got %h expected %h", k, obs, exp_vec());
            end
        end
        #3 rstn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset_midburst: got %h expected 0", obs);
        end
        @(posedge clk);
        #3 rstn = 1'b1;
        tick();
        checks++;
        if (obs !== {16'h0001, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ptr_after_reset: got %h expected %h", obs, {16'h0001, 4'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_single_req();
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'h0020;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (obs !== {16'h0020, 4'd5, 1'b1, 1'((k % 4) == 0)}) begin
                errors++;
                $display("FAIL single_req[%0d]: got %h expected %h", k, obs,
                         {16'h0020, 4'd5, 1'b1, 1'((k % 4) == 0)});
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single_req_model[%0d]: got %h expected %h", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_all_req();
        logic [N+SW+1:0] e;
        int s;
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'hFFFF;
        for (int k = 1; k <= 16 * BL + BL; k++) begin
            tick();
            s = ((k - 1) / BL) % N;
            e = {N'(1) << s, SW'(s), 1'b1, 1'((k % BL) == 0)};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL all_req_rotation[%0d]: got %h expected %h", k, obs, e);
            end
        end
    endtask

    task automatic test_pair();
        logic [N+SW+1:0] e;
        int s;
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'h8001;
        for (int k = 1; k <= 18; k++) begin
            tick();
            s = (((k - 1) / BL) % 2 == 1) ? 15 : 0;
            e = {N'(1) << s, SW'(s), 1'b1, 1'((k % BL) == 0)};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL pair_order[%0d]: got %h expected %h", k, obs, e);
            end
        end
        bus.req = 16'h8000;
        tick();
        checks++;
        if (obs !== {16'h8000, 4'd15, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL early_drop: got %h expected %h", obs, {16'h8000, 4'd15, 1'b1, 1'b0});
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL early_drop_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_en_low();
        logic [N+SW+1:0] e [8];
        e[0] = {16'h0002, 4'd1, 1'b1, 1'b0};
        e[1] = {16'h0002, 4'd1, 1'b1, 1'b0};
        e[2] = {16'h0002, 4'd1, 1'b1, 1'b0};
        e[3] = {16'h0002, 4'd1, 1'b1, 1'b1};
        e[4] = '0;
        e[5] = '0;
        e[6] = '0;
        e[7] = {16'h0004, 4'd2, 1'b1, 1'b0};
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'h0006;
        for (int s = 0; s < 8; s++) begin
            if (s == 2) bus.en = 1'b0;
            if (s == 7) bus.en = 1'b1;
            tick();
            checks++;
            if (obs !== e[s]) begin
                errors++;
                $display("FAIL en_low[%0d]: got %h expected %h", s, obs, e[s]);
            end
        end
    endtask

    task automatic test_mux();
        do_reset();
        mux_in  = 16'hA5A5;
        bus.en  = 1'b1;
        bus.req = 16'hFFFF;
        for (int k = 1; k <= 40; k++) begin
            if (k == 30) bus.en = 1'b0;
            tick();
            checks++;
            if (mux_out !== exp_mux()) begin
                errors++;
                $display("FAIL mux_stream[%0d]: got %b expected %b", k, mux_out, exp_mux());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        mux_in = N'($urandom);
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(3) == 0) bus.req = N'($urandom) & N'($urandom);
            bus.en = ($urandom_range(9) != 0);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", k, obs, exp_vec());
            end
            checks++;
            if (mux_out !== exp_mux()) begin
                errors++;
                $display("FAIL random_mux[%0d]: got %b expected %b", k, mux_out, exp_mux());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_all_req();
        test_pair();
        test_en_low();
        test_mux();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
